// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX path: state encoding, start-pulse length
// and watchdog counter width.
package uart_pkg;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] START     = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;
   localparam logic [1:0] GAP       = 2'd3;

   localparam int START_CYCLES = 2;
   localparam int WD_W         = 16;

   typedef enum logic [1:0] {
      S_IDLE      = IDLE,
      S_START     = START,
      S_WAIT_DONE = WAIT_DONE,
      S_GAP       = GAP
   } state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester handshake, transmitter control and status bundle for uart_tx_arb.
// The slave modport is the arbiter; the master modport is its environment.
interface uart_tx_arb_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int GID_W      = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_run_n;
   logic                          tx_done;
   logic                          busy;
   logic [GID_W-1:0]              grant_id;
   logic                          timeout_err;
   logic                          clr_err;

   modport master (
      output req_valid, req_data, tx_done, clr_err,
      input  req_ready, tx_data, tx_run_n, busy, grant_id, timeout_err
   );

   modport slave (
      input  req_valid, req_data, tx_done, clr_err,
      output req_ready, tx_data, tx_run_n, busy, grant_id, timeout_err
   );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first valid requester searching upward from
// last_grant+1, wrapping modulo NUM_REQ.
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GID_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req_valid,
   input  logic [GID_W-1:0]   i_last_grant,
   output logic               o_any_valid,
   output logic [GID_W-1:0]   o_winner
);

   logic [GID_W:0] w_idx;

   // Walk from the farthest offset to the nearest so the nearest valid wins.
   always_comb begin
      o_any_valid = 1'b0;
      o_winner    = '0;
      w_idx       = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         w_idx = {1'b0, i_last_grant} + (GID_W+1)'(i);
         if (w_idx >= (GID_W+1)'(NUM_REQ)) begin
            w_idx = w_idx - (GID_W+1)'(NUM_REQ);
         end
         if (i_req_valid[w_idx[GID_W-1:0]]) begin
            o_any_valid = 1'b1;
            o_winner    = w_idx[GID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between NUM_REQ
// byte producers, with a watchdog on the transmitter's end-of-frame pulse.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for any req_valid; grants and latches the winner
// S_START     | tx_run_n held low for START_CYCLES cycles
// S_WAIT_DONE | waiting for tx_done; watchdog abandons frame on timeout
// S_GAP       | one settling cycle before the next arbitration
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int              NUM_REQ        = 4,
   parameter int              DATA_WIDTH     = 8,
   parameter logic [WD_W-1:0] TIMEOUT_CYCLES = 16'd8192,
   parameter int              GID_W          = $clog2(NUM_REQ)
) (
   input logic         clk,
   input logic         rstn,
   uart_tx_arb_if.slave bus
);

   state_t                r_state;
   logic [1:0]            r_start_cnt;
   logic [WD_W-1:0]       r_wd_cnt;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic [GID_W-1:0]      r_grant_id;
   logic [GID_W-1:0]      r_last_grant;
   logic [NUM_REQ-1:0]    r_req_ready;
   logic                  r_tx_run_n;
   logic                  r_busy;
   logic                  r_timeout_err;

   state_t                w_next_state;
   logic [1:0]            w_start_cnt;
   logic [WD_W-1:0]       w_wd_cnt;
   logic [DATA_WIDTH-1:0] w_tx_data;
   logic [GID_W-1:0]      w_grant_id;
   logic [GID_W-1:0]      w_last_grant;
   logic [NUM_REQ-1:0]    w_req_ready;
   logic                  w_timeout_set;
   logic                  w_any_valid;
   logic [GID_W-1:0]      w_winner;
   logic [DATA_WIDTH-1:0] w_win_data;
   logic [NUM_REQ-1:0]    w_win_onehot;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .GID_W   (GID_W)
   ) u_pick (
      .i_req_valid  (bus.req_valid),
      .i_last_grant (r_last_grant),
      .o_any_valid  (w_any_valid),
      .o_winner     (w_winner)
   );

   always_comb begin
      w_win_data   = '0;
      w_win_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winner == GID_W'(i)) begin
            w_win_data      = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            w_win_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_start_cnt   = r_start_cnt;
      w_wd_cnt      = r_wd_cnt;
      w_tx_data     = r_tx_data;
      w_grant_id    = r_grant_id;
      w_last_grant  = r_last_grant;
      w_req_ready   = '0;
      w_timeout_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_valid) begin
               w_next_state = S_START;
               w_tx_data    = w_win_data;
               w_grant_id   = w_winner;
               w_last_grant = w_winner;
               w_req_ready  = w_win_onehot;
               w_start_cnt  = '0;
            end
         end
         S_START: begin
            if (r_start_cnt == 2'(START_CYCLES - 1)) begin
               w_next_state = S_WAIT_DONE;
               w_wd_cnt     = '0;
            end else begin
               w_start_cnt = r_start_cnt + 2'd1;
            end
         end
         S_WAIT_DONE: begin
            w_wd_cnt = r_wd_cnt + WD_W'(1);
            // A done pulse on the final watchdog cycle still counts as success.
            if (bus.tx_done) begin
               w_next_state = S_GAP;
            end else if (r_wd_cnt == TIMEOUT_CYCLES - WD_W'(1)) begin
               w_timeout_set = 1'b1;
               w_next_state  = S_GAP;
            end
         end
         S_GAP: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state       <= S_IDLE;
         r_start_cnt   <= '0;
         r_wd_cnt      <= '0;
         r_tx_data     <= '0;
         r_grant_id    <= '0;
         r_last_grant  <= GID_W'(NUM_REQ - 1);
         r_req_ready   <= '0;
         r_tx_run_n    <= 1'b1;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_start_cnt   <= w_start_cnt;
         r_wd_cnt      <= w_wd_cnt;
         r_tx_data     <= w_tx_data;
         r_grant_id    <= w_grant_id;
         r_last_grant  <= w_last_grant;
         r_req_ready   <= w_req_ready;
         r_tx_run_n    <= (w_next_state != S_START);
         r_busy        <= (w_next_state != S_IDLE);
         if (w_timeout_set) begin
            r_timeout_err <= 1'b1;
         end else if (bus.clr_err) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   assign bus.req_ready   = r_req_ready;
   assign bus.tx_data     = r_tx_data;
   assign bus.tx_run_n    = r_tx_run_n;
   assign bus.busy        = r_busy;
   assign bus.grant_id    = r_grant_id;
   assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: a scoreboard of expected grants checked by a
// monitor, a small transmitter model, and inline status checks.
module tb_uart_tx_arb;

   typedef struct {
      logic [3:0] rdy;
      logic [7:0] data;
      logic [1:0] gid;
   } sb_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   uart_tx_arb_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

   uart_tx_arb #(
      .NUM_REQ        (4),
      .DATA_WIDTH     (8),
      .TIMEOUT_CYCLES (16'd16)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int  n_pass  = 0;
   int  n_total = 0;
   sb_t sb_q[$];
   bit  tx_en   = 1'b1;
   bit  spur    = 1'b0;
   int  mdl_cnt = -1;
   bit  mdl_prev = 1'b1;
   int  lowcnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input logic [3:0] rdy, input logic [7:0] data, input logic [1:0] gid);
      sb_t e;
      e.rdy  = rdy;
      e.data = data;
      e.gid  = gid;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] d);
      bus.req_valid = v;
      bus.req_data  = d;
   endtask

   task automatic wait_ready(input logic [3:0] mask);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if ((bus.req_ready & mask) != 4'b0) begin
            ok = 1'b1;
            break;
         end
      end
      check("grant_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(output int n);
      bit ok;
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         n++;
         if (bus.tx_done) begin
            ok = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_seen", 32'(ok), 32'd1);
   endtask

   // Transmitter model: frame of 3 cycles after the start pulse ends.
   initial begin
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         bus.tx_done = 1'b0;
         if (!rstn) begin
            mdl_cnt = -1;
         end else begin
            if (spur) begin
               bus.tx_done = 1'b1;
               spur = 1'b0;
            end
            if (mdl_cnt == 0) begin
               bus.tx_done = 1'b1;
               mdl_cnt = -1;
            end else if (mdl_cnt > 0) begin
               mdl_cnt--;
            end
            if (!mdl_prev && bus.tx_run_n && tx_en) mdl_cnt = 2;
         end
         mdl_prev = bus.tx_run_n;
      end
   end

   // Monitor: pops the scoreboard on every grant and checks start-pulse width.
   initial begin
      sb_t e;
      forever begin
         cyc();
         if (bus.req_ready != 4'b0) begin
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL grant_unexpected: req_ready=%b, none expected", bus.req_ready);
            end else begin
               e = sb_q.pop_front();
               check("grant_ready", 32'(bus.req_ready), 32'(e.rdy));
               check("grant_data", 32'(bus.tx_data), 32'(e.data));
               check("grant_id", 32'(bus.grant_id), 32'(e.gid));
            end
         end
         if (!bus.tx_run_n) begin
            lowcnt++;
         end else if (lowcnt != 0) begin
            check("run_n_low_len", 32'(lowcnt), 32'd2);
            lowcnt = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rstn        = 1'b0;
      bus.clr_err = 1'b0;
      drive(4'b0, 32'h0);
      repeat (3) cyc();
      check("rst_run_n", 32'(bus.tx_run_n), 32'd1);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_gid", 32'(bus.grant_id), 32'd0);
      check("rst_terr", 32'(bus.timeout_err), 32'd0);
      rstn = 1'b1;
      cyc();

      // Single request from requester 2
      expect_grant(4'b0100, 8'hA5, 2'd2);
      drive(4'b0100, 32'h00A5_0000);
      wait_ready(4'b0100);
      drive(4'b0, 32'h00A5_0000);
      wait_done(n);
      check("t1_busy_gap", 32'(bus.busy), 32'd1);
      cyc();
      check("t1_busy_idle", 32'(bus.busy), 32'd0);

      // Fairness from reset priority
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      expect_grant(4'b0001, 8'h10, 2'd0);
      expect_grant(4'b0010, 8'h11, 2'd1);
      expect_grant(4'b0100, 8'h12, 2'd2);
      expect_grant(4'b1000, 8'h13, 2'd3);
      expect_grant(4'b0001, 8'h10, 2'd0);
      drive(4'b1111, 32'h1312_1110);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (bus.req_ready != 4'b0) n++;
         if (n == 5) begin
            drive(4'b0, 32'h0);
            break;
         end
      end
      check("t2_grants", 32'(n), 32'd5);
      wait_idle();

      // Data changes after acceptance
      expect_grant(4'b0010, 8'h3C, 2'd1);
      drive(4'b0010, 32'h0000_3C00);
      wait_ready(4'b0010);
      drive(4'b0, 32'h0000_C300);
      cyc();
      check("t3_hold_mid", 32'(bus.tx_data), 32'h3C);
      wait_idle();
      check("t3_hold_end", 32'(bus.tx_data), 32'h3C);
      expect_grant(4'b0010, 8'hC3, 2'd1);
      drive(4'b0010, 32'h0000_C300);
      wait_ready(4'b0010);
      drive(4'b0, 32'h0);
      wait_idle();

      // Watchdog timeout
      tx_en = 1'b0;
      expect_grant(4'b0001, 8'h5A, 2'd0);
      drive(4'b0001, 32'h0000_005A);
      wait_ready(4'b0001);
      drive(4'b0, 32'h0);
      repeat (17) cyc();
      check("t4_terr_before", 32'(bus.timeout_err), 32'd0);
      check("t4_busy_wait", 32'(bus.busy), 32'd1);
      cyc();
      check("t4_terr_set", 32'(bus.timeout_err), 32'd1);
      check("t4_busy_gap", 32'(bus.busy), 32'd1);
      cyc();
      check("t4_busy_idle", 32'(bus.busy), 32'd0);
      tx_en = 1'b1;
      expect_grant(4'b1000, 8'h77, 2'd3);
      drive(4'b1000, 32'h7700_0000);
      wait_ready(4'b1000);
      drive(4'b0, 32'h0);
      wait_idle();
      check("t4_sticky", 32'(bus.timeout_err), 32'd1);
      bus.clr_err = 1'b1;
      cyc();
      bus.clr_err = 1'b0;
      check("t4_cleared", 32'(bus.timeout_err), 32'd0);
      tx_en = 1'b0;
      expect_grant(4'b0100, 8'h99, 2'd2);
      drive(4'b0100, 32'h0099_0000);
      wait_ready(4'b0100);
      drive(4'b0, 32'h0);
      repeat (17) cyc();
      bus.clr_err = 1'b1;
      cyc();
      bus.clr_err = 1'b0;
      check("t4_set_wins", 32'(bus.timeout_err), 32'd1);
      wait_idle();

      // Reset during WAIT_DONE
      expect_grant(4'b0010, 8'h21, 2'd1);
      drive(4'b0010, 32'h0000_2100);
      wait_ready(4'b0010);
      drive(4'b0, 32'h0);
      repeat (3) cyc();
      rstn = 1'b0;
      cyc();
      check("t5_run_n", 32'(bus.tx_run_n), 32'd1);
      check("t5_busy", 32'(bus.busy), 32'd0);
      check("t5_ready", 32'(bus.req_ready), 32'd0);
      check("t5_terr", 32'(bus.timeout_err), 32'd0);
      check("t5_gid", 32'(bus.grant_id), 32'd0);
      rstn  = 1'b1;
      tx_en = 1'b1;
      expect_grant(4'b0001, 8'h31, 2'd0);
      drive(4'b0101, 32'h0032_0031);
      wait_ready(4'b0001);
      drive(4'b0, 32'h0);
      wait_idle();

      // Spurious tx_done while idle
      spur = 1'b1;
      repeat (3) cyc();
      check("t6_idle_busy", 32'(bus.busy), 32'd0);
      expect_grant(4'b1000, 8'hE7, 2'd3);
      drive(4'b1000, 32'hE700_0000);
      wait_ready(4'b1000);
      drive(4'b0, 32'h0);
      wait_done(n);
      check("t6_frame_len", 32'(n), 32'd6);
      check("t6_busy_gap", 32'(bus.busy), 32'd1);
      cyc();
      check("t6_busy_idle", 32'(bus.busy), 32'd0);

      repeat (5) cyc();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares one UART transmitter between `NUM_REQ` byte producers. It accepts bytes over a valid/ready handshake, latches the winning byte, starts a frame on the transmitter, and waits for end-of-frame before granting again. It also provides a watchdog on the transmitter's done pulse. It sits between the command/debug sources and the single serial TX pin path.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: byte width presented to the transmitter.
- `TIMEOUT_CYCLES`, 16'd8192: maximum cycles spent in WAIT_DONE before the frame is abandoned.
- `GID_W`, `$clog2(NUM_REQ)`: width of `grant_id`.

Ports:
- `clk`  in  1  clock; reset `rstn` is synchronous, active-low.
- `rstn`  in  1  synchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i byte at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse: byte of that requester accepted.
- `tx_data`  out  DATA_WIDTH  byte driven to the transmitter; registered, stable for the whole frame.
- `tx_run_n`  out  1  active-low frame start to the transmitter.
- `tx_done`  in  1  transmitter end-of-frame pulse, one cycle wide.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  GID_W  index of the requester currently or last served.
- `timeout_err`  out  1  sticky: a frame exceeded `TIMEOUT_CYCLES`.
- `clr_err`  in  1  clears `timeout_err`.

## Operation
- States: IDLE, START, WAIT_DONE, GAP.
- **IDLE:** if any `req_valid` is set, select the winner by round-robin.
  - Search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - On the next edge: `tx_data` is loaded with the winner's byte, `grant_id` and `last_grant` are set to the winner, `req_ready[winner]` is 1 for that cycle, and the FSM moves to START.
  - With no valid requester, the FSM stays in IDLE.
- **START:** `tx_run_n`=0 for exactly 2 cycles (2-bit counter), then go to WAIT_DONE.
  - `tx_run_n` is 1 in every other state, so the transmitter never restarts on its own after DONE.
- **WAIT_DONE:** the 16-bit `wd_cnt` increments every cycle.
  - If `tx_done`=1, go to GAP.
  - Else if `wd_cnt`==`TIMEOUT_CYCLES`-1, set `timeout_err` and go to GAP.
  - `tx_done` takes priority over timeout in the same cycle.
  - `wd_cnt` is cleared on entry to WAIT_DONE.
- **GAP:** 1 cycle, lets the transmitter return to idle, then go to IDLE.
  - Back-to-back frames are therefore separated by a minimum IDLE→START turnaround.
- `tx_done` outside WAIT_DONE is ignored.
- Requester rules:
  - Hold `req_valid` and `req_data` stable until `req_ready` is seen.
  - After the `req_ready` cycle, either drop `req_valid` or present the next byte.
  - A requester deasserting `req_valid` before grant simply loses the arbitration; there is no error.
- `timeout_err`: set by a timeout, cleared by `clr_err`. Set wins if both occur in the same cycle.

## Timing
- **Reset (rstn=0 at an edge) values:**
  - state=IDLE, `tx_run_n`=1, `tx_data`=0, `req_ready`=0, `busy`=0.
  - `grant_id`=0, `last_grant`=NUM_REQ-1 (requester 0 has first priority), `timeout_err`=0, `wd_cnt`=0.
- Reset mid-frame aborts immediately with the same values; the transmitter's own reset handles its frame.
- **Latency:**
  - `req_valid` sampled at edge k in IDLE.
  - `req_ready`, `tx_data`, and `tx_run_n`=0 are visible in cycle k+1.
  - `tx_run_n` is low in cycles k+1 and k+2.
- **Throughput:** one byte per (frame length + 5) cycles.
  - Cycles: IDLE + 2 START + done-detect + GAP.
- **Fairness:** with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0.
- All outputs are registered; there is no combinational path from `req_valid` to `req_ready`.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding localparams (IDLE=2'd0, START=2'd1, WAIT_DONE=2'd2, GAP=2'd3);
  - the `START_CYCLES`=2 constant;
  - the watchdog counter width (16).
- Sub-module `uart_rr_pick`: combinational round-robin pick.
  - Inputs: `req_valid` and `last_grant`.
  - Outputs: `any_valid` and `winner` index.
  - Reused later for the RX-side buffer drain.
- The top contains the FSM, data latch, and watchdog.

## Test plan
- Reset then single request: req 2 valid, data 8'hA5 → `req_ready`=4'b0100 for 1 cycle; `tx_data`=8'hA5; `tx_run_n` low exactly 2 cycles; `busy` falls 2 cycles after the model's `tx_done`.
- All 4 requesters continuously valid with data 8'h10..8'h13 → transmitted order 10,11,12,13,10; no requester is granted twice in a row.
- `req_data` changed the cycle after `req_ready` → `tx_data` stays at the latched byte until the next grant.
- `tx_done` withheld, `TIMEOUT_CYCLES`=16 → `timeout_err`=1 after 16 WAIT_DONE cycles; FSM back in IDLE 2 cycles later; next request served normally; `clr_err` clears the flag. `clr_err` asserted in the same cycle as a timeout leaves the flag at 1.
- `rstn` low during WAIT_DONE → next cycle `tx_run_n`=1, `busy`=0, `req_ready`=0; next grant goes to requester 0 if valid.
- Spurious `tx_done` pulse in IDLE, then a request → pulse ignored; full START/WAIT_DONE sequence occurs.
